pd_debug_cfg_loader: RTL

//  Configuration sequencer for the PD debug match datapath. On request it fetches the four

---
 rtl/pd_debug_cfg_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pd_debug_cfg_loader.sv
// pd_debug_cfg_loader
//   Configuration sequencer for the PD debug match datapath. On request it
//   reads the four match words of one regarray set from config memory. The
//   words are field1 value/mask and field2 value/mask. They are collected in
//   shadow registers and then committed atomically to the active set. The
//   commit is held off while a PD is being evaluated (e_valid high), so the
//   debug block never sees a half-updated set.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cfg_load_req        1-cycle load request
//   cfg_load_set        target set index
//   cfg_load_base_addr  memory address of word 0
//   cfg_load_busy       loader not idle
//   cfg_load_done       1-cycle pulse: set committed
//   cfg_load_err        1-cycle pulse: read timeout, load aborted
//   cfg_load_rej        1-cycle pulse: request rejected (busy or bad set)
//   mem_rd_req          1-cycle read strobe
//   mem_rd_addr         read address, valid with mem_rd_req
//   mem_rd_valid        read data valid
//   mem_rd_data         read data
//   e_valid             PD evaluated by debug block this cycle
//   cfg_f1_value/mask   active field1 words, set i at [i*PD_WIDTH +: PD_WIDTH]
//   cfg_f2_value/mask   active field2 words, same packing
//   cfg_set_valid       bit i = set i committed since reset
module pd_debug_cfg_loader #(
  parameter int PD_WIDTH       = 32,
  parameter int NUM_SETS       = 3,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SET_W         = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_load_req,
  input  logic [SET_W-1:0]             cfg_load_set,
  input  logic [MEM_ADDR_WIDTH-1:0]    cfg_load_base_addr,
  output logic                         cfg_load_busy,
  output logic                         cfg_load_done,
  output logic                         cfg_load_err,
  output logic                         cfg_load_rej,
  output logic                         mem_rd_req,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic                         mem_rd_valid,
  input  logic [PD_WIDTH-1:0]          mem_rd_data,
  input  logic                         e_valid,
  output logic [NUM_SETS*PD_WIDTH-1:0] cfg_f1_value,
  output logic [NUM_SETS*PD_WIDTH-1:0] cfg_f1_mask,
  output logic [NUM_SETS*PD_WIDTH-1:0] cfg_f2_value,
  output logic [NUM_SETS*PD_WIDTH-1:0] cfg_f2_mask,
  output logic [NUM_SETS-1:0]          cfg_set_valid
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, COMMIT} state_t;

  state_t                    state;
  logic [SET_W-1:0]          set_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [1:0]                word_idx;
  logic [TCNT_W-1:0]         tcnt;
  logic [PD_WIDTH-1:0]       sh_f1_value;
  logic [PD_WIDTH-1:0]       sh_f1_mask;
  logic [PD_WIDTH-1:0]       sh_f2_value;
  logic [PD_WIDTH-1:0]       sh_f2_mask;
  logic                      set_ok;

  // The set index port can encode more values than there are sets.
  assign set_ok = 32'(cfg_load_set) < NUM_SETS;

  // Single FSM. Outputs are registered and set on the transition into the
  // state they belong to. As a result, mem_rd_req/addr are valid for exactly
  // the REQ cycle, and busy tracks state != IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      set_q         <= '0;
      base_q        <= '0;
      word_idx      <= '0;
      tcnt          <= '0;
      sh_f1_value   <= '0;
      sh_f1_mask    <= '0;
      sh_f2_value   <= '0;
      sh_f2_mask    <= '0;
      cfg_load_busy <= 1'b0;
      cfg_load_done <= 1'b0;
      cfg_load_err  <= 1'b0;
      cfg_load_rej  <= 1'b0;
      mem_rd_req    <= 1'b0;
      mem_rd_addr   <= '0;
      cfg_f1_value  <= '0;
      cfg_f1_mask   <= '0;
      cfg_f2_value  <= '0;
      cfg_f2_mask   <= '0;
      cfg_set_valid <= '0;
    end else begin
      cfg_load_done <= 1'b0;
      cfg_load_err  <= 1'b0;
      cfg_load_rej  <= 1'b0;
      mem_rd_req    <= 1'b0;

      // A request is rejected while busy or with an out-of-range set.
      // A load already in progress is not disturbed by it.
      if (cfg_load_req && ((state != IDLE) || !set_ok)) begin
        cfg_load_rej <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cfg_load_req && set_ok) begin
            set_q         <= cfg_load_set;
            base_q        <= cfg_load_base_addr;
            word_idx      <= 2'd0;
            mem_rd_req    <= 1'b1;
            mem_rd_addr   <= cfg_load_base_addr;
            cfg_load_busy <= 1'b1;
            state         <= REQ;
          end
        end

        REQ: begin
          tcnt  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (mem_rd_valid) begin
            case (word_idx)
              2'd0:    sh_f1_value <= mem_rd_data;
              2'd1:    sh_f1_mask  <= mem_rd_data;
              2'd2:    sh_f2_value <= mem_rd_data;
              default: sh_f2_mask  <= mem_rd_data;
            endcase
            if (word_idx == 2'd3) begin
              state <= COMMIT;
            end else begin
              // Address arithmetic wraps naturally at the memory width.
              word_idx    <= word_idx + 2'd1;
              mem_rd_req  <= 1'b1;
              mem_rd_addr <= base_q + {{(MEM_ADDR_WIDTH-2){1'b0}}, word_idx + 2'd1};
              state       <= REQ;
            end
          end else if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This cycle is the TIMEOUT_CYCLES-th one without data. The shadow
            // contents are simply abandoned and the active sets stay as they were.
            cfg_load_err  <= 1'b1;
            cfg_load_busy <= 1'b0;
            state         <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        COMMIT: begin
          if (!e_valid) begin
            for (int i = 0; i < NUM_SETS; i++) begin
              if (32'(set_q) == i) begin
                cfg_f1_value[i*PD_WIDTH +: PD_WIDTH] <= sh_f1_value;
                cfg_f1_mask[i*PD_WIDTH +: PD_WIDTH]  <= sh_f1_mask;
                cfg_f2_value[i*PD_WIDTH +: PD_WIDTH] <= sh_f2_value;
                cfg_f2_mask[i*PD_WIDTH +: PD_WIDTH]  <= sh_f2_mask;
                cfg_set_valid[i]                     <= 1'b1;
              end
            end
            cfg_load_done <= 1'b1;
            cfg_load_busy <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
